// File: rtl/lcd_cmd_pkg.sv
// Shared definitions for the LCD command decoder: opcodes, decoder states
// and the power-on drawing window.
package lcd_cmd_pkg;

  localparam logic [7:0] OP_SWRESET = 8'h01;
  localparam logic [7:0] OP_SLPOUT  = 8'h11;
  localparam logic [7:0] OP_DISPOFF = 8'h28;
  localparam logic [7:0] OP_DISPON  = 8'h29;
  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_PASET   = 8'h2B;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;
  localparam logic [7:0] OP_COLMOD  = 8'h3A;

  localparam logic [15:0] DEF_SC = 16'd0;
  localparam logic [15:0] DEF_EC = 16'd239;
  localparam logic [15:0] DEF_SP = 16'd0;
  localparam logic [15:0] DEF_EP = 16'd319;
  localparam logic [7:0]  DEF_COLMOD = 8'h66;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET_P,
    ST_PASET_P,
    ST_COLMOD_P,
    ST_RAM_LO,
    ST_RAM_HI,
    ST_BUSY
  } dec_state_t;

endpackage

// File: rtl/lcd_cmd_decoder_if.sv
// Host-side byte bus into the LCD command decoder.
interface lcd_cmd_decoder_if;
  // A byte is taken on the first clk cycle where wr is high after a cycle
  // with wr low; dcx and d must be stable in that cycle. No back-pressure.
  logic       wr;
  logic       dcx;
  logic [7:0] d;

  modport master (output wr, dcx, d);
  modport slave  (input  wr, dcx, d);
endinterface

// File: rtl/lcd_window_counter.sv
// Pixel pointer inside the current drawing window; raster order, wraps
// back to the top-left corner after the last row.
module lcd_window_counter (
  input  logic        clk,
  input  logic        nrst,
  input  logic        load,
  input  logic        advance,
  input  logic [15:0] sc,
  input  logic [15:0] ec,
  input  logic [15:0] sp,
  input  logic [15:0] ep,
  output logic [15:0] col,
  output logic [15:0] row
);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      col <= 16'd0;
      row <= 16'd0;
    end else if (load) begin
      col <= sc;
      row <= sp;
    end else if (advance) begin
      if (col >= ec) begin
        col <= sc;
        row <= (row >= ep) ? sp : row + 16'd1;
      end else begin
        col <= col + 16'd1;
      end
    end
  end

endmodule

// File: rtl/lcd_cmd_decoder.sv
// Decodes a DCX-qualified byte stream (ILI9341-style command set) into
// window/status registers and a stream of addressed RGB565 pixels.
module lcd_cmd_decoder
  import lcd_cmd_pkg::*;
#(
  parameter int BUSY_CYCLES = 60000,
  parameter int COORD_W     = 16
) (
  input  logic               clk,
  input  logic               nrst,
  lcd_cmd_decoder_if.slave   bus,
  output logic               pix_valid,
  output logic [COORD_W-1:0] pix_col,
  output logic [COORD_W-1:0] pix_row,
  output logic [15:0]        pix_color,
  output logic               frame_start,
  output logic               disp_on,
  output logic               sleep_out,
  output logic [7:0]         colmod,
  output logic               busy,
  output logic               err_unknown,
  output logic               err_stray,
  output logic               err_timing,
  output dec_state_t         state
);

  localparam int CNT_W = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_CYCLES - 1);

  logic             wr_q;
  logic             accept;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       pidx;
  logic [23:0]      pbuf;
  logic [7:0]       color_lo;
  logic [15:0]      sc, ec, sp, ep;
  logic [15:0]      col, row;
  logic             ptr_load, ptr_adv;

  assign accept   = bus.wr & ~wr_q;
  assign ptr_load = accept & ~bus.dcx & (state != ST_BUSY) & (bus.d == OP_RAMWR);
  assign ptr_adv  = accept & bus.dcx & (state == ST_RAM_HI);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) wr_q <= 1'b0;
    else       wr_q <= bus.wr;
  end

  lcd_window_counter u_ptr (
    .clk     (clk),
    .nrst    (nrst),
    .load    (ptr_load),
    .advance (ptr_adv),
    .sc      (sc),
    .ec      (ec),
    .sp      (sp),
    .ep      (ep),
    .col     (col),
    .row     (row)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      pidx        <= 2'd0;
      pbuf        <= 24'd0;
      color_lo    <= 8'd0;
      sc          <= DEF_SC;
      ec          <= DEF_EC;
      sp          <= DEF_SP;
      ep          <= DEF_EP;
      pix_valid   <= 1'b0;
      pix_col     <= '0;
      pix_row     <= '0;
      pix_color   <= 16'd0;
      frame_start <= 1'b0;
      disp_on     <= 1'b0;
      sleep_out   <= 1'b0;
      colmod      <= DEF_COLMOD;
      busy        <= 1'b0;
      err_unknown <= 1'b0;
      err_stray   <= 1'b0;
      err_timing  <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      err_unknown <= 1'b0;
      err_stray   <= 1'b0;
      err_timing  <= 1'b0;

      if (state == ST_BUSY) begin
        // Lockout: bytes are dropped, never queued for later.
        if (accept) err_timing <= 1'b1;
        if (cnt == CNT_LAST) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (accept && !bus.dcx) begin
        pidx <= 2'd0;
        case (bus.d)
          OP_SWRESET: begin
            sc        <= DEF_SC;
            ec        <= DEF_EC;
            sp        <= DEF_SP;
            ep        <= DEF_EP;
            disp_on   <= 1'b0;
            sleep_out <= 1'b0;
            colmod    <= DEF_COLMOD;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= ST_BUSY;
          end
          OP_SLPOUT: begin
            sleep_out <= 1'b1;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= ST_BUSY;
          end
          OP_DISPOFF: begin disp_on <= 1'b0; state <= ST_IDLE; end
          OP_DISPON:  begin disp_on <= 1'b1; state <= ST_IDLE; end
          OP_CASET:   state <= ST_CASET_P;
          OP_PASET:   state <= ST_PASET_P;
          OP_COLMOD:  state <= ST_COLMOD_P;
          OP_RAMWR: begin
            frame_start <= 1'b1;
            state       <= ST_RAM_LO;
          end
          default: begin
            err_unknown <= 1'b1;
            state       <= ST_IDLE;
          end
        endcase
      end else if (accept) begin
        case (state)
          ST_CASET_P, ST_PASET_P: begin
            // Window registers change only once all four bytes arrived.
            pidx <= pidx + 2'd1;
            case (pidx)
              2'd0: pbuf[23:16] <= bus.d;
              2'd1: pbuf[15:8]  <= bus.d;
              2'd2: pbuf[7:0]   <= bus.d;
              default: begin
                if (state == ST_CASET_P) begin
                  sc <= pbuf[23:8];
                  ec <= {pbuf[7:0], bus.d};
                end else begin
                  sp <= pbuf[23:8];
                  ep <= {pbuf[7:0], bus.d};
                end
                state <= ST_IDLE;
              end
            endcase
          end
          ST_COLMOD_P: begin
            colmod <= bus.d;
            state  <= ST_IDLE;
          end
          ST_RAM_LO: begin
            color_lo <= bus.d;
            state    <= ST_RAM_HI;
          end
          ST_RAM_HI: begin
            pix_valid <= 1'b1;
            pix_col   <= col[COORD_W-1:0];
            pix_row   <= row[COORD_W-1:0];
            pix_color <= {bus.d, color_lo};
            state     <= ST_RAM_LO;
          end
          default: err_stray <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: doc/lcd_cmd_decoder.md
LCD_CMD_DECODER -- requirements
Module: lcd_cmd_decoder

Interface
REQ-001 SHALL provide parameter BUSY_CYCLES, default 60000: length of the post-SWRESET/SLPOUT lockout, in clk cycles.
REQ-002 SHALL provide parameter COORD_W, default 16: width of the pixel coordinate outputs.
REQ-003 clk  input  1  system clock; all logic on posedge.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 wr  input  1  write strobe, active-high, synchronous to clk.
REQ-006 dcx  input  1  0 = command byte, 1 = data/parameter byte.
REQ-007 d  input  8  bus byte.
REQ-008 pix_valid  output  1  one-cycle pulse: a complete pixel is on pix_col/pix_row/pix_color.
REQ-009 pix_col, pix_row  output  COORD_W  pixel column (CASET axis) and row (PASET axis).
REQ-010 pix_color  output  16  RGB565 pixel value.
REQ-011 frame_start  output  1  one-cycle pulse on acceptance of RAMWR (0x2C).
REQ-012 disp_on, sleep_out  output  1  display-on and sleep-out status flags.
REQ-013 colmod  output  8  last accepted COLMOD parameter.
REQ-014 busy  output  1  high during lockout.
REQ-015 err_unknown, err_stray, err_timing  output  1  one-cycle pulses: unknown opcode; data byte while IDLE; byte received while busy.

Function
REQ-016 Byte acceptance SHALL occur in a cycle where wr=1 and wr was 0 in the previous cycle; the previous-wr register SHALL reset to 0.
REQ-017 All outputs SHALL be registered; a pulse or flag update SHALL appear in the cycle following the accepting cycle.
REQ-018 States SHALL be IDLE, CASET_P, PASET_P, COLMOD_P, RAM_LO, RAM_HI, BUSY.
REQ-019 A command byte accepted in any state other than BUSY SHALL abort the current sequence and be decoded immediately.
REQ-020 Opcode 0x01 SWRESET SHALL set the window to SC=0, EC=239, SP=0, EP=319, and set disp_on=0, sleep_out=0, colmod=0x66, then enter BUSY.
REQ-021 Opcode 0x11 SLPOUT SHALL set sleep_out=1 and enter BUSY.
REQ-022 Opcode 0x28 SHALL clear disp_on; opcode 0x29 SHALL set disp_on; both SHALL return to IDLE.
REQ-023 Opcode 0x3A SHALL enter COLMOD_P; the next data byte SHALL be copied to colmod, then the FSM SHALL return to IDLE.
REQ-024 Opcode 0x2A/0x2B SHALL enter CASET_P/PASET_P with a 2-bit parameter index and capture parameters in the order start[15:8], start[7:0], end[15:8], end[7:0].
REQ-025 The new start/end (SC/EC or SP/EP) SHALL commit only on the 4th parameter; an aborted sequence SHALL leave the window unchanged.
REQ-026 Opcode 0x2C SHALL load the pixel pointer to (SC, SP), pulse frame_start, and enter RAM_LO.
REQ-027 In RAM_LO, a data byte SHALL be latched as color[7:0] and the FSM SHALL move to RAM_HI.
REQ-028 In RAM_HI, a data byte SHALL form color[15:8], pulse pix_valid with the current pointer, advance the pointer, and return to RAM_LO.
REQ-029 Pointer advance: if col >= EC, col SHALL become SC and the row SHALL advance, otherwise col+1; if row >= EP when advancing, row SHALL become SP (wrap, no error), otherwise row+1.
REQ-030 Any other opcode SHALL pulse err_unknown and return to IDLE.
REQ-031 A data byte in IDLE SHALL be ignored and pulse err_stray.
REQ-032 In BUSY, a counter SHALL run from 0 and busy=1; any accepted byte SHALL be dropped with err_timing.
REQ-033 On counter = BUSY_CYCLES-1, the FSM SHALL go to IDLE; busy SHALL fall the next cycle.
REQ-034 Coordinate outputs SHALL be the low COORD_W bits of the 16-bit pointer.

Reset
REQ-035 On nrst=0 (asynchronous) the state SHALL be IDLE and the window SC=0, EC=239, SP=0, EP=319.
REQ-036 On reset, pointer, counter and color SHALL clear to 0; colmod SHALL be 0x66; all flags and pulses SHALL be 0.
REQ-037 Reset asserted mid-sequence SHALL discard partial parameters and partial pixels; no pulse SHALL be emitted.

Structure
REQ-038 Package lcd_cmd_pkg SHALL hold the opcode constants (0x01, 0x11, 0x28, 0x29, 0x2A, 0x2B, 0x2C, 0x3A), the decoder state enum and the default window values.
REQ-039 Pointer storage and advance SHALL live in sub-module lcd_window_counter (inputs load/advance/SC/EC/SP/EP; outputs col/row).

Verification
REQ-040 Bench SHALL check: 0x2A, 00, 00, 00, 0x13, then 0x2B, 00, 00, 00, 0x13, then 0x2C with 2 pixel pairs (0x14, 0x08) -> frame_start pulse, 2 pix_valid at (0,0) and (1,0), pix_color=0x0814.
REQ-041 Bench SHALL check: window col 0..1, row 0..1, 5 pixels -> coordinates (0,0), (1,0), (0,1), (1,1), (0,0).
REQ-042 Bench SHALL check: 0x01, then 0x29 at cycle 10 -> err_timing, disp_on stays 0, busy high for BUSY_CYCLES cycles; after that, 0x29 -> disp_on=1.
REQ-043 Bench SHALL check: 0x2A, 00, 0x14, then 0x2C -> CASET aborted, pointer loads SC=0.
REQ-044 Bench SHALL check: data byte 0x55 in IDLE -> err_stray; opcode 0x36 -> err_unknown; 0x3A, 0x55 -> colmod=0x55.
REQ-045 Bench SHALL check: nrst pulsed after the RAM_LO byte -> no pix_valid, state IDLE, window at default values.
